// File: rtl/radix_codec_iter_if.sv
// Request/response bundle for radix_codec_iter: valid/ready request channel
// carrying operand, direction, radix and tag, plus the matching result channel.
interface radix_codec_iter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_dir;
    logic [1:0]            in_radix;
    logic [ID_WIDTH-1:0]   in_id;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_err;
    logic [ID_WIDTH-1:0]   out_id;

    modport slave (
        input  in_valid, in_data, in_dir, in_radix, in_id, out_ready,
        output in_ready, out_valid, out_data, out_err, out_id
    );

    modport master (
        output in_valid, in_data, in_dir, in_radix, in_id, out_ready,
        input  in_ready, out_valid, out_data, out_err, out_id
    );
endinterface

// File: rtl/radix_codec_iter.sv
// Iterative binary <-> packed radix-10/12 digit codec, one digit per cycle.
// Optional statistics counters are built when RADIX_CODEC_STATS_EN is defined.
module radix_codec_iter #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_DIGITS = 16,
    parameter int ID_WIDTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    radix_codec_iter_if.slave bus,
    output logic [31:0]       stat_count,
    output logic [15:0]       stat_errors
);

    localparam int DIGW = 4 * NUM_DIGITS;
    localparam int KW   = $clog2(NUM_DIGITS + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ENC  = 2'd1;
    localparam logic [1:0] ST_DEC  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] RADIX_2   = 2'b00;
    localparam logic [1:0] RADIX_10  = 2'b01;
    localparam logic [1:0] RADIX_12  = 2'b10;
    localparam logic [1:0] RADIX_BAD = 2'b11;

    localparam logic [KW-1:0] LAST_K = KW'(NUM_DIGITS - 1);

    logic [1:0]            state_r;
    logic [1:0]            radix_r;
    logic [ID_WIDTH-1:0]   id_r;
    logic [DATA_WIDTH-1:0] q_r;
    logic [DATA_WIDTH-1:0] res_r;
    logic [KW-1:0]         k_r;
    logic                  err_r;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic                  out_err_r;
    logic [ID_WIDTH-1:0]   out_id_r;

    logic [3:0]            radix_val_s;
    logic [DATA_WIDTH-1:0] divisor_s;
    logic [DATA_WIDTH-1:0] quo_s;
    logic [3:0]            enc_digit_s;
    logic [DATA_WIDTH-1:0] enc_res_s;
    logic [3:0]            dec_digit_s;
    logic [DATA_WIDTH+3:0] prod_s;
    logic                  dec_ovf_s;
    logic                  dec_bad_digit_s;
    logic                  out_fire_s;

    // Radix value selected by the latched request
    always_comb begin
        radix_val_s = 4'd10;
        case (radix_r)
            RADIX_10: radix_val_s = 4'd10;
            RADIX_12: radix_val_s = 4'd12;
            default:  radix_val_s = 4'd10;
        endcase
    end

    // Encode step: full-width divide, remainder is the next digit
    always_comb begin
        divisor_s   = {{(DATA_WIDTH-4){1'b0}}, radix_val_s};
        quo_s       = q_r / divisor_s;
        enc_digit_s = 4'(q_r - quo_s * divisor_s);
        enc_res_s   = res_r;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (k_r == KW'(i)) begin
                enc_res_s[4*i +: 4] = enc_digit_s;
            end else begin
                enc_res_s[4*i +: 4] = res_r[4*i +: 4];
            end
        end
    end

    // Decode step: product is 4 bits wider so overflow shows up in the top nibble
    always_comb begin
        dec_digit_s     = q_r[DIGW-1 -: 4];
        prod_s          = {4'b0000, res_r} * {{DATA_WIDTH{1'b0}}, radix_val_s}
                        + {{DATA_WIDTH{1'b0}}, dec_digit_s};
        dec_ovf_s       = |prod_s[DATA_WIDTH+3:DATA_WIDTH];
        dec_bad_digit_s = (dec_digit_s >= radix_val_s);
    end

    assign out_fire_s    = out_valid_r && bus.out_ready;
    assign bus.in_ready  = (state_r == ST_IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_err   = out_err_r;
    assign bus.out_id    = out_id_r;

    // Control FSM, working registers and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            radix_r     <= RADIX_2;
            id_r        <= '0;
            q_r         <= '0;
            res_r       <= '0;
            k_r         <= '0;
            err_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_err_r   <= 1'b0;
            out_id_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        id_r    <= bus.in_id;
                        radix_r <= bus.in_radix;
                        q_r     <= bus.in_data;
                        k_r     <= '0;
                        case (bus.in_radix)
                            RADIX_2: begin
                                res_r   <= bus.in_data;
                                err_r   <= 1'b0;
                                state_r <= ST_DONE;
                            end
                            RADIX_BAD: begin
                                res_r   <= '0;
                                err_r   <= 1'b1;
                                state_r <= ST_DONE;
                            end
                            default: begin
                                res_r   <= '0;
                                err_r   <= 1'b0;
                                state_r <= bus.in_dir ? ST_DEC : ST_ENC;
                            end
                        endcase
                    end
                end
                ST_ENC: begin
                    res_r <= enc_res_s;
                    q_r   <= quo_s;
                    k_r   <= k_r + KW'(1);
                    if (quo_s == '0) begin
                        state_r <= ST_DONE;
                    end else if (k_r == LAST_K) begin
                        // Digits exhausted with quotient left over
                        err_r   <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DEC: begin
                    res_r <= prod_s[DATA_WIDTH-1:0];
                    q_r   <= {q_r[DATA_WIDTH-5:0], 4'b0000};
                    k_r   <= k_r + KW'(1);
                    if (dec_ovf_s || dec_bad_digit_s) begin
                        err_r <= 1'b1;
                    end
                    if (k_r == LAST_K) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= err_r ? '0 : res_r;
                        out_err_r   <= err_r;
                        out_id_r    <= id_r;
                    end else if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef RADIX_CODEC_STATS_EN
    logic [31:0] stat_count_r;
    logic [15:0] stat_errors_r;

    // Completed-conversion counters; error count saturates instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_count_r  <= 32'd0;
            stat_errors_r <= 16'd0;
        end else if (out_fire_s) begin
            stat_count_r <= stat_count_r + 32'd1;
            if (out_err_r && (stat_errors_r != 16'hFFFF)) begin
                stat_errors_r <= stat_errors_r + 16'd1;
            end
        end
    end

    assign stat_count  = stat_count_r;
    assign stat_errors = stat_errors_r;
`else
    assign stat_count  = 32'd0;
    assign stat_errors = 16'd0;
`endif

endmodule

// File: tb/tb_radix_codec_iter.sv
// Self-checking bench for radix_codec_iter: vector table plus scoreboard,
// with hand-written back-pressure, mid-conversion reset and statistics sequences.
module tb_radix_codec_iter;

    localparam int DW = 64;
    localparam int ND = 16;
    localparam int IW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] stat_count;
    logic [15:0] stat_errors;
    int          cyc = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    typedef struct {
        logic [63:0] data;
        logic        err;
        logic [3:0]  id;
        int          lat;
    } exp_t;

    typedef struct {
        logic        dir;
        logic [1:0]  radix;
        logic [63:0] data;
        logic [3:0]  id;
        logic [63:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    radix_codec_iter_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    radix_codec_iter #(.DATA_WIDTH(DW), .NUM_DIGITS(ND), .ID_WIDTH(IW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .stat_count  (stat_count),
        .stat_errors (stat_errors)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic note_fail(input string name);
        total_cnt++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic void add_vec(input logic dir, input logic [1:0] radix, input logic [63:0] data,
                                    input logic [3:0] id, input logic [63:0] ed, input logic ee, input int el);
        vec_t v;
        v.dir = dir; v.radix = radix; v.data = data; v.id = id;
        v.exp_data = ed; v.exp_err = ee; v.exp_lat = el;
        vecs.push_back(v);
    endfunction

    // Reference encoder from positional weights: digit i = (v / r^i) mod r
    function automatic void enc_model(input logic [63:0] v, input int r,
                                      output logic [63:0] d, output int nd);
        logic [63:0] p;
        p = 64'd1;
        d = 64'd0;
        nd = 0;
        for (int i = 0; i < ND; i++) begin
            d[4*i +: 4] = 4'((v / p) % 64'(r));
            if (v >= p) nd = i + 1;
            p = p * 64'(r);
        end
        if (nd == 0) nd = 1;
    endfunction

    task automatic send(input logic dir, input logic [1:0] radix, input logic [63:0] data,
                        input logic [3:0] id, input exp_t e, output int acc_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            note_fail("accept");
            acc_cyc = -1;
        end else begin
            bus.in_dir   = dir;
            bus.in_radix = radix;
            bus.in_data  = data;
            bus.in_id    = id;
            bus.in_valid = 1'b1;
            @(negedge clk);
            acc_cyc      = cyc;
            bus.in_valid = 1'b0;
            bus.in_data  = {$urandom, $urandom};
            bus.in_id    = ~id;
            sb_q.push_back(e);
        end
    endtask

    task automatic collect(input string name, input int acc_cyc);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) begin
            note_fail({name, ".valid"});
            if (sb_q.size() > 0) e = sb_q.pop_front();
        end else if (sb_q.size() == 0) begin
            note_fail({name, ".scoreboard"});
        end else begin
            e = sb_q.pop_front();
            chk({name, ".data"}, bus.out_data, e.data);
            chk({name, ".err"},  64'(bus.out_err), 64'(e.err));
            chk({name, ".id"},   64'(bus.out_id), 64'(e.id));
            chk({name, ".lat"},  64'(cyc - acc_cyc), 64'(e.lat));
            @(negedge clk);
            chk({name, ".valid_drop"}, 64'(bus.out_valid), 64'd0);
            chk({name, ".ready_back"}, 64'(bus.in_ready), 64'd1);
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        exp_t e;
        int   acc;
        e.data = v.exp_data; e.err = v.exp_err; e.id = v.id; e.lat = v.exp_lat;
        send(v.dir, v.radix, v.data, v.id, e, acc);
        if (acc >= 0) collect(name, acc);
    endtask

    task automatic chk_reset_values(input string name);
        chk({name, ".in_ready"},    64'(bus.in_ready), 64'd1);
        chk({name, ".out_valid"},   64'(bus.out_valid), 64'd0);
        chk({name, ".out_data"},    bus.out_data, 64'd0);
        chk({name, ".out_err"},     64'(bus.out_err), 64'd0);
        chk({name, ".out_id"},      64'(bus.out_id), 64'd0);
        chk({name, ".stat_count"},  64'(stat_count), 64'd0);
        chk({name, ".stat_errors"}, 64'(stat_errors), 64'd0);
    endtask

    initial begin
        exp_t        e;
        vec_t        v;
        int          acc;
        int          nd;
        logic [63:0] val;
        logic [63:0] dig;
        logic        seen;

        bus.in_valid  = 1'b0;
        bus.in_data   = 64'd0;
        bus.in_dir    = 1'b0;
        bus.in_radix  = 2'b00;
        bus.in_id     = 4'h0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_values("por");
        rst_n = 1'b1;

        add_vec(1'b0, 2'b01, 64'd1234,                4'h1, 64'h1234,              1'b0, 5);
        add_vec(1'b0, 2'b01, 64'd0,                   4'h2, 64'h0,                 1'b0, 2);
        add_vec(1'b0, 2'b10, 64'd1728,                4'h3, 64'h1000,              1'b0, 5);
        add_vec(1'b0, 2'b10, 64'd131,                 4'h9, 64'hAB,                1'b0, 3);
        add_vec(1'b1, 2'b10, 64'hAB,                  4'h4, 64'd131,               1'b0, 17);
        add_vec(1'b1, 2'b01, 64'hA5,                  4'h5, 64'd0,                 1'b1, 17);
        add_vec(1'b0, 2'b01, 64'd10000000000000000,   4'h6, 64'd0,                 1'b1, 17);
        add_vec(1'b0, 2'b11, 64'h1234,                4'h7, 64'd0,                 1'b1, 1);
        add_vec(1'b0, 2'b00, 64'hDEADBEEF,            4'h8, 64'hDEADBEEF,          1'b0, 1);
        add_vec(1'b1, 2'b00, 64'hFEDCBA9876543210,    4'hA, 64'hFEDCBA9876543210,  1'b0, 1);
        add_vec(1'b1, 2'b11, 64'h55,                  4'hB, 64'd0,                 1'b1, 1);
        add_vec(1'b0, 2'b01, 64'd9999999999999999,    4'hC, 64'h9999999999999999,  1'b0, 17);
        add_vec(1'b1, 2'b01, 64'h9999999999999999,    4'hD, 64'd9999999999999999,  1'b0, 17);
        add_vec(1'b0, 2'b10, 64'd184884258895036416,  4'hE, 64'd0,                 1'b1, 17);
        add_vec(1'b0, 2'b10, 64'd184884258895036415,  4'hF, 64'hBBBBBBBBBBBBBBBB,  1'b0, 17);
        add_vec(1'b1, 2'b01, 64'h0B,                  4'h1, 64'd0,                 1'b1, 17);
        add_vec(1'b1, 2'b10, 64'h0B,                  4'h2, 64'd11,                1'b0, 17);
        add_vec(1'b1, 2'b10, 64'hC0,                  4'h3, 64'd0,                 1'b1, 17);
        add_vec(1'b0, 2'b01, 64'd9,                   4'h4, 64'h9,                 1'b0, 2);
        add_vec(1'b0, 2'b01, 64'd10,                  4'h5, 64'h10,                1'b0, 3);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Random round trips: encode against the positional model, decode back to the original
        for (int i = 0; i < 4; i++) begin
            val = {$urandom, $urandom} % 64'd1000000000000000;
            enc_model(val, (i % 2 == 1) ? 12 : 10, dig, nd);
            v.dir = 1'b0; v.radix = (i % 2 == 1) ? 2'b10 : 2'b01; v.data = val;
            v.id = 4'(i); v.exp_data = dig; v.exp_err = 1'b0; v.exp_lat = nd + 1;
            run_vec($sformatf("rnd_enc%0d", i), v);
            v.dir = 1'b1; v.data = dig; v.exp_data = val; v.exp_lat = ND + 1;
            run_vec($sformatf("rnd_dec%0d", i), v);
        end

        // Back-pressure: result held while out_ready is low, new request stays pending
        bus.out_ready = 1'b0;
        e.data = 64'h1234; e.err = 1'b0; e.id = 4'h3; e.lat = 5;
        send(1'b0, 2'b01, 64'd1234, 4'h3, e, acc);
        seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            if (bus.out_valid) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            note_fail("stall.valid");
        end else begin
            chk("stall.lat", 64'(cyc - acc), 64'd5);
            bus.in_dir = 1'b0; bus.in_radix = 2'b01; bus.in_data = 64'd77; bus.in_id = 4'h5;
            bus.in_valid = 1'b1;
            for (int n = 0; n < 6; n++) begin
                chk($sformatf("stall%0d.valid", n), 64'(bus.out_valid), 64'd1);
                chk($sformatf("stall%0d.data", n), bus.out_data, 64'h1234);
                chk($sformatf("stall%0d.in_ready", n), 64'(bus.in_ready), 64'd0);
                @(negedge clk);
            end
            e = sb_q.pop_front();
            chk("stall.id", 64'(bus.out_id), 64'(e.id));
            bus.out_ready = 1'b1;
            @(negedge clk);
            chk("stall.ready_back", 64'(bus.in_ready), 64'd1);
            chk("stall.valid_drop", 64'(bus.out_valid), 64'd0);
            e.data = 64'h77; e.err = 1'b0; e.id = 4'h5; e.lat = 3;
            sb_q.push_back(e);
            @(negedge clk);
            acc = cyc;
            bus.in_valid = 1'b0;
            collect("held", acc);
        end

        // Reset during the third encode cycle aborts the conversion silently
        @(negedge clk);
        bus.in_dir = 1'b0; bus.in_radix = 2'b01; bus.in_data = 64'd1000000000000000;
        bus.in_id = 4'h6; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_values("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("midrst.no_result", 64'(seen), 64'd0);

        // Three good and two errored conversions after reset
        add_vec(1'b0, 2'b01, 64'd4321, 4'h7, 64'h4321, 1'b0, 5);
        run_vec("post_rst", vecs[vecs.size()-1]);
        run_vec("stat_g1", vecs[0]);
        run_vec("stat_e1", vecs[5]);
        run_vec("stat_g2", vecs[3]);
        run_vec("stat_e2", vecs[7]);
`ifdef RADIX_CODEC_STATS_EN
        chk("stat_count", 64'(stat_count), 64'd5);
        chk("stat_errors", 64'(stat_errors), 64'd2);
`else
        chk("stat_count", 64'(stat_count), 64'd0);
        chk("stat_errors", 64'(stat_errors), 64'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/radix_codec_iter.md
Name: radix_codec_iter

Overview:
Iterative, parametrised radix codec. Converts unsigned binary to packed 4-bit-per-digit radix-10 (BCD) or radix-12 (dozenal) form ("encode"), and packed digits back to binary ("decode").
One digit is processed per cycle. Input and output use valid/ready handshakes, and a tag travels with each request.
It sits between the market-data fixed-point datapath and the display/logging paths. It replaces single-shot conversion with a bounded-latency, overflow-checked engine.

Parameters:
DATA_WIDTH, 64, binary operand width. Must be >= 4*NUM_DIGITS.
NUM_DIGITS, 16, packed digit capacity. Digits occupy bits [4*NUM_DIGITS-1:0]; digit 0 is least significant.
ID_WIDTH, 4, request tag width.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  engine idle, request accepted on in_valid&&in_ready
in_data  input  DATA_WIDTH  binary (encode) or packed digits (decode)
in_dir  input  1  0=encode binary->digits, 1=decode digits->binary
in_radix  input  2  00=radix 2 (pass-through), 01=radix 10, 10=radix 12, 11=illegal
in_id  input  ID_WIDTH  request tag
out_valid  output  1  result valid
out_ready  input  1  consumer accepts on out_valid&&out_ready
out_data  output  DATA_WIDTH  result
out_err  output  1  overflow, illegal digit or illegal radix
out_id  output  ID_WIDTH  echoed tag
stat_count  output  32  completed conversions (see Optional Feature)
stat_errors  output  16  errored conversions (see Optional Feature)

Behaviour:
- Reset is asynchronous, rst_n active-low; clock clk.
  - Reset forces IDLE. Reset values: in_ready=1, out_valid=0, out_data=0, out_err=0, out_id=0, stat_count=0, stat_errors=0.
  - Reset mid-conversion aborts silently: no result is produced.
- States: IDLE, ENC, DEC, DONE.
  - in_ready=1 only in IDLE.
  - Accept in IDLE latches data, dir, radix and id.
  - Radix 00 or 11 goes directly to DONE.
  - Otherwise the engine enters ENC or DEC according to in_dir.
- Radix 2: out_data=in_data, out_err=0. out_valid is asserted the cycle after acceptance.
- Radix 11: out_data=0, out_err=1. Same 1-cycle latency as radix 2.
- ENC (encode):
  - Per cycle: digit[k] = q mod R, q = q / R, k++. Both are computed combinationally on the full DATA_WIDTH.
  - ENC exits to DONE when q becomes 0 after the digit is written, or when k reaches NUM_DIGITS.
  - Input 0 yields exactly one digit (0).
  - If q != 0 after NUM_DIGITS digits: out_err=1 and out_data=0.
  - Bits above 4*NUM_DIGITS are always 0.
  - Latency from the accept edge to out_valid is k+1 cycles, where k is the number of digits produced.
- DEC (decode):
  - Processes digits NUM_DIGITS-1 down to 0, one per cycle: acc = acc*R + d.
  - Always takes NUM_DIGITS cycles; latency is NUM_DIGITS+1.
  - Any digit >= R sets a sticky error.
  - acc*R + d exceeding 2^DATA_WIDTH-1 sets a sticky error. The overflow check uses an extended-width product.
  - On error: out_data=0, out_err=1.
  - Input bits above 4*NUM_DIGITS are ignored.
- DONE: out_valid=1, and out_data/out_err/out_id are held stable until out_ready.
  - On out_valid&&out_ready, the engine returns to IDLE (in_ready=1 next cycle). No back-to-back overlap.
  - If out_ready is high on DONE entry, out_valid is high for exactly 1 cycle.
- in_data and in_id changing after acceptance have no effect.
- in_valid while busy is ignored: the request is not accepted, and the upstream holds it.

Optional Feature:
Macro RADIX_CODEC_STATS_EN.
- Defined:
  - stat_count increments by one on each output handshake, wrapping at 2^32.
  - stat_errors increments by one on each handshake with out_err=1, saturating at 16'hFFFF.
  - Both counters are cleared only by reset.
- Undefined: both ports are tied to 0 and the counters are not synthesised.

Test Plan:
1. Encode: in_data=1234, radix 10 -> out_data=64'h1234, err=0, out_valid 5 cycles after accept. Input 0 -> out_data=0, latency 2.
2. Encode: 1728, radix 12 -> 64'h1000. Encode 131, radix 12 -> 64'hAB. Tag in_id=4'h9 is echoed on out_id.
3. Decode: 64'hAB, radix 12 -> 131, latency 17. Decode 64'hA5, radix 10 -> err=1, out_data=0.
4. Overflow: encode 10^16, radix 10 (NUM_DIGITS=16) -> err=1, data=0, latency 17. Radix 11 -> err=1 after 1 cycle. Radix 2 on 64'hDEADBEEF -> passes through unchanged.
5. Handshake: out_ready held low 6 cycles -> out_valid and out_data stable, in_ready=0, new in_valid not accepted. After out_ready pulses, in_ready=1 the next cycle.
6. Reset/stats: rst_n asserted during ENC cycle 3 -> all outputs at reset values and no out_valid, then a clean conversion follows. With RADIX_CODEC_STATS_EN, after 3 good and 2 errored conversions: stat_count=5, stat_errors=2.
